// File: rtl/ms_latch_if.sv
// Per-bit set/reset request and complementary stored-value signals of an
// ms_latch bank.
interface ms_latch_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_l;

  // Requester drives set/reset and observes the stored value.
  modport master (
    output s,
    output r,
    input  q,
    input  q_l
  );

  // The storage cell consumes set/reset and drives the stored value.
  modport slave (
    input  s,
    input  r,
    output q,
    output q_l
  );
endinterface

// File: rtl/ms_latch.sv
// Master-slave SR flip-flop bank: a clk-high master SR latch feeding a clk-low
// slave latch, so q moves only on the falling edge of clk.
module ms_latch #(
  parameter int WIDTH = 1
) (
  input  logic       clk,
  input  logic       rst_l,
  ms_latch_if.slave  bus
);

  logic [WIDTH-1:0] master;
  logic [WIDTH-1:0] slave;

  logic [WIDTH-1:0] m_set;
  logic [WIDTH-1:0] m_clr;
  logic [WIDTH-1:0] s_set;
  logic [WIDTH-1:0] s_clr;

  // Gated SR decode. S=R=1 asserts neither set nor clear, so it resolves to hold.
  always_comb begin
    m_set = '0;
    m_clr = '0;
    s_set = '0;
    s_clr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m_set[i] = clk  &  bus.s[i] & ~bus.r[i];
      m_clr[i] = clk  & ~bus.s[i] &  bus.r[i];
      s_set[i] = ~clk &  master[i];
      s_clr[i] = ~clk & ~master[i];
    end
  end

  // NOTE: these are deliberate level-sensitive latches; any bit with neither
  // set nor clear active is left unassigned so it holds its value.
  always_latch begin
    if (!rst_l) begin
      master <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (m_set[i]) begin
          master[i] <= 1'b1;
        end else if (m_clr[i]) begin
          master[i] <= 1'b0;
        end
      end
    end
  end

  // Slave copies the master only while clk is low; s/r never reach it directly.
  always_latch begin
    if (!rst_l) begin
      slave <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s_set[i]) begin
          slave[i] <= 1'b1;
        end else if (s_clr[i]) begin
          slave[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.q   = slave;
  assign bus.q_l = ~slave;

endmodule

// File: tb/tb_ms_latch.sv
// Directed bench for a 2-bit ms_latch bank: expected q values are queued as the
// stimulus is applied and compared at the sample points that follow.
`timescale 1ns/1ps
module tb_ms_latch;

  localparam int W = 2;

  typedef struct {
    string      tag;
    logic [W-1:0] q;
  } exp_t;

  logic clk;
  logic rst_l;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  ms_latch_if #(.WIDTH(W)) bus ();

  ms_latch #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  // Starts high: falling edges at 95 + 190k ns, rising edges at 190k ns.
  initial clk = 1'b1;
  always #95 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic at(input longint t);
    if ($time < t) #(t - $time);
  endtask

  task automatic drive(input logic [W-1:0] s, input logic [W-1:0] r);
    bus.s = s;
    bus.r = r;
  endtask

  task automatic expect_q(input string tag, input logic [W-1:0] q);
    exp_t e;
    e.tag = tag;
    e.q   = q;
    sb.push_back(e);
  endtask

  task automatic check_at(input longint t);
    exp_t         e;
    logic [W-1:0] exp_ql;
    at(t);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >0 at %0t", $time);
    end
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      exp_ql = ~e.q;
      checks++;
      assert (bus.q === e.q) else begin
        errors++;
        $error("FAIL %s q: observed %b expected %b at %0t", e.tag, bus.q, e.q, $time);
      end
      checks++;
      assert (bus.q_l === exp_ql) else begin
        errors++;
        $error("FAIL %s q_l: observed %b expected %b at %0t", e.tag, bus.q_l, exp_ql, $time);
      end
    end
  endtask

  initial begin
    // Reset asserted with bit0 set request held: nothing may be captured.
    rst_l = 1'b0;
    drive(2'b01, 2'b10);
    expect_q("reset_immediate", 2'b00);
    check_at(1);
    expect_q("reset_ignores_s", 2'b00);
    check_at(40);

    // Release mid-high phase: bit0 set, bit1 reset, visible at 95 ns.
    at(50);
    rst_l = 1'b1;
    expect_q("set_first_fall", 2'b01);
    expect_q("set_fall_285", 2'b01);
    expect_q("set_fall_475", 2'b01);
    check_at(96);
    check_at(286);
    check_at(476);

    // Reset bit0 / set bit1 during low phase: captured at 570, visible at 665.
    at(500);
    drive(2'b10, 2'b01);
    expect_q("slave_holds_high", 2'b01);
    expect_q("reset_req_665", 2'b10);
    expect_q("reset_req_855", 2'b10);
    check_at(600);
    check_at(666);
    check_at(856);

    // Hold: bit0 stays 0, bit1 stays 1.
    at(1000);
    drive(2'b00, 2'b00);
    expect_q("hold_1045", 2'b10);
    expect_q("hold_1235", 2'b10);
    expect_q("hold_1425", 2'b10);
    check_at(1046);
    check_at(1236);
    check_at(1426);

    // Forbidden S=R=1 holds the previous value without X.
    at(1500);
    drive(2'b11, 2'b11);
    expect_q("forbidden_1615", 2'b10);
    expect_q("forbidden_1805", 2'b10);
    expect_q("forbidden_1995", 2'b10);
    check_at(1616);
    check_at(1806);
    check_at(1996);
    at(2000);
    drive(2'b00, 2'b00);

    // 10 ns set pulse on bit0 in the 2090-2185 high phase.
    at(2100);
    drive(2'b01, 2'b00);
    at(2110);
    drive(2'b00, 2'b00);
    expect_q("set_pulse_high", 2'b11);
    check_at(2186);

    // 10 ns reset pulse on bit1 in the 2280-2375 high phase.
    at(2300);
    drive(2'b00, 2'b10);
    at(2310);
    drive(2'b00, 2'b00);
    expect_q("reset_pulse_high", 2'b01);
    check_at(2376);

    // Set then reset pulse on bit0 in one high phase: the later reset wins.
    at(2480);
    drive(2'b01, 2'b00);
    at(2490);
    drive(2'b00, 2'b00);
    at(2500);
    drive(2'b00, 2'b01);
    at(2510);
    drive(2'b00, 2'b00);
    expect_q("last_request_wins", 2'b00);
    check_at(2566);

    // Set pulse entirely inside a low phase is never captured.
    at(2600);
    drive(2'b01, 2'b00);
    at(2610);
    drive(2'b00, 2'b00);
    expect_q("low_pulse_ignored", 2'b00);
    check_at(2756);

    // Set held from a low phase: captured at 2850 rise, visible at 2945 fall.
    at(2800);
    drive(2'b01, 2'b00);
    expect_q("low_no_capture", 2'b00);
    expect_q("captured_not_shown", 2'b00);
    expect_q("low_set_latency", 2'b01);
    check_at(2840);
    check_at(2900);
    check_at(2946);
    at(2950);
    drive(2'b00, 2'b00);

    // Reset mid-high phase after a set request: no set at the next fall.
    at(3050);
    drive(2'b10, 2'b00);
    at(3060);
    rst_l = 1'b0;
    expect_q("reset_mid_high", 2'b00);
    check_at(3061);
    at(3065);
    drive(2'b00, 2'b00);
    at(3070);
    rst_l = 1'b1;
    expect_q("no_set_after_reset", 2'b00);
    check_at(3136);

    // Set bit0 again, then reset during a low phase clears it immediately.
    at(3240);
    drive(2'b01, 2'b00);
    expect_q("set_again", 2'b01);
    check_at(3326);
    at(3330);
    drive(2'b00, 2'b00);
    at(3350);
    rst_l = 1'b0;
    expect_q("reset_low_phase", 2'b00);
    check_at(3351);
    at(3360);
    rst_l = 1'b1;
    expect_q("stays_clear", 2'b00);
    check_at(3516);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
